dbg_access_ctrl: RTL
====================

# dbg_access_ctrl

Host-side access controller that sequences external debug/loader traffic into the pipelined core. It accepts one host request at a time over a four-phase req/ack handshake, freezes the pipeline and waits for it to drain, then performs a single register-file read, instruction-memory write, or data-memory read/write through the cache/regfile external ports. Afterwards it returns data and releases the core. It sits between the board/host interface and the core's external ports, and replaces direct decoding of the raw `cmd` bus.

## Interface
- DRAIN_CYCLES, 4, cycles `core_halt` must be continuously high before memory/regfile access is legal (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- run_en  in  1  host wants the core running when no transaction is active
- host_req  in  1  request; four-phase handshake with `host_ack`
- host_cmd  in  2  00 REG_RD, 01 IMEM_WR, 10 DMEM_RD, 11 DMEM_WR; sampled with request
- host_addr  in  32  byte address (bits [1:0] ignored); REG_RD uses [4:0]
- host_wdata  in  32  write data; sampled with request
- host_ack  out  1  response valid; held until `host_req` low
- host_rdata  out  32  read result; valid while `host_ack`=1; 0 for writes
- host_busy  out  1  state != IDLE
- core_halt  out  1  to PC/IF-ID stall; freezes fetch
- core_halted  out  1  `core_halt` has been high ≥ DRAIN_CYCLES consecutive cycles
- imem_we  out  1  I-cache port-A write strobe
- dmem_we  out  4  D-cache port-B byte write strobes
- mem_addr  out  30  word address to I/D-cache external ports
- mem_wdata  out  32  write data
- reg_addr  out  5  regfile external read index
- dmem_rdata  in  32  D-cache port-B data (1-cycle registered read)
- reg_rdata  in  32  regfile external read data

## Operation
- FSM states: IDLE, HALT, ACCESS, WAIT, RESP.
- IDLE: on an edge with `host_req`=1 and `host_ack`=0, latch cmd/addr/wdata.
  - Go to ACCESS if `halt_cnt`==DRAIN_CYCLES; otherwise go to HALT.
  - Set `core_halt`=1.
- HALT: `core_halt`=1. Go to ACCESS on the edge where `halt_cnt` reaches DRAIN_CYCLES.
- `halt_cnt`: counts consecutive cycles with `core_halt`=1 and saturates at DRAIN_CYCLES. It clears in the same edge that `core_halt` falls. `core_halted` = (`halt_cnt`==DRAIN_CYCLES).
- ACCESS (1 cycle):
  - `mem_addr` = addr[31:2] and `reg_addr` = addr[4:0].
  - IMEM_WR: `imem_we`=1, `mem_wdata`=wdata.
  - DMEM_WR: `dmem_we`=4'b1111, `mem_wdata`=wdata.
  - Reads: strobes 0.
  - Writes go next to RESP; reads go to WAIT.
- WAIT (1 cycle): addresses held. At the end, capture into `host_rdata`: REG_RD → `reg_rdata`, DMEM_RD → `dmem_rdata`. Then go to RESP.
- RESP: `host_ack`=1 and `host_rdata` stable. On an edge with `host_req`=0: go to IDLE, `host_ack`←0, `core_halt`←!`run_en`.
- IDLE without a transaction: `core_halt` tracks !`run_en` with one-cycle registered delay.
- Strobes are single-cycle pulses and are only ever high in ACCESS. `mem_addr`, `reg_addr` and `mem_wdata` are 0 in IDLE.
- Changes to `host_cmd`, `host_addr` or `host_wdata` after the sampling edge are ignored.
- Dropping `host_req` before `host_ack` does not abort. The transaction completes, `host_ack` pulses for one cycle, and the FSM returns to IDLE.
- Changes to `run_en` mid-transaction take effect only on return to IDLE.
- REG_RD of x0 returns whatever the regfile returns; no special case.

## Timing
- Reset (`reset`=0 at an edge), from any state, mid-operation included:
  - state = IDLE, `halt_cnt` = 0.
  - All outputs 0: `core_halt`, `core_halted`, `host_ack`, `host_busy`, `host_rdata`, strobes, addresses.
  - An in-flight access is abandoned; no strobe fires after reset.
- Edge E0 samples the request. Ack-high latency from E0:
  - Core running (`halt_cnt`=0), read: `host_ack` high after edge E0+DRAIN_CYCLES+2.
  - Core running (`halt_cnt`=0), write: after edge E0+DRAIN_CYCLES+1.
  - Core already halted (`core_halted`=1), read: after E0+2.
  - Core already halted (`core_halted`=1), write: after E0+1.
  - Partially drained (0<`halt_cnt`<DRAIN_CYCLES): HALT covers only the remaining cycles.
- Back-to-back: the next request is accepted no earlier than the edge after `host_ack` falls, with `host_req` re-asserted.
  - If `run_en`=1, the core runs one cycle between requests, so the drain restarts.
- `host_busy` rises at E0+1 and falls on the edge `host_ack` falls.

## Test plan
- Reset mid-HALT: `run_en`=1, DMEM_WR, then `reset`=0 two cycles after E0 → all outputs 0 next edge, `dmem_we` never asserted, D-cache word unchanged.
- Running core, DMEM_RD addr 0x0000_0010 with the D-cache word = 0xDEAD_BEEF, DRAIN_CYCLES=4 → `host_ack` high after E0+6, `host_rdata`=0xDEAD_BEEF, `core_halt`=1 from E0+1 until ack drop, then 0.
- `run_en`=0 for ≥4 cycles, then IMEM_WR addr 0x8 data 0x0000_0013 → `imem_we` pulses one cycle with `mem_addr`=2, ack after E0+1, `core_halt` stays 1 afterwards.
- REG_RD addr 5 with x5=0x1234_5678, core halted → ack after E0+2, `host_rdata`=0x1234_5678; `host_addr` changed at E0+1 has no effect.
- Early req drop: DMEM_WR 0xA5A5_A5A5, `host_req` low at E0+1 → `dmem_we`=4'hF for exactly one cycle, `host_ack` one-cycle pulse, IDLE afterwards.
- Held req after ack: `host_req` kept high 5 cycles past `host_ack` → `host_ack` held, no second access; the next request is accepted only after a low/high req cycle.

Source files
------------

// File: rtl/dbg_access_ctrl.sv
// Host debug/loader access sequencer: halts and drains the core, performs one
// regfile read or I/D-memory access, then returns data over a four-phase req/ack.
module dbg_access_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        host_req,
  input  logic [1:0]  host_cmd,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        host_busy,
  output logic        core_halt,
  output logic        core_halted,
  output logic        imem_we,
  output logic [3:0]  dmem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [4:0]  reg_addr,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] reg_rdata
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] DrainMax = CntW'(DRAIN_CYCLES);

  localparam logic [1:0] CmdRegRd  = 2'b00;
  localparam logic [1:0] CmdImemWr = 2'b01;
  localparam logic [1:0] CmdDmemWr = 2'b11;

  typedef enum logic [2:0] {StIdle, StHalt, StAccess, StWait, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] halt_cnt_q, halt_cnt_d;
  logic            core_halt_q, core_halt_d;
  logic [1:0]      cmd_q, acc_cmd;
  logic [31:0]     addr_q, acc_addr;
  logic [31:0]     wdata_q, acc_wdata;
  logic            accept;

  assign accept = host_req && !host_ack;

  always_comb begin
    core_halt_d = core_halt_q;
    unique case (state_q)
      StIdle:  core_halt_d = accept ? 1'b1 : !run_en;
      StResp:  core_halt_d = host_req ? 1'b1 : !run_en;
      default: core_halt_d = 1'b1;
    endcase
    // Counts only cycles already spent halted; clears as soon as halt drops.
    halt_cnt_d = halt_cnt_q;
    if (!core_halt_d) begin
      halt_cnt_d = '0;
    end else if (core_halt_q && halt_cnt_q != DrainMax) begin
      halt_cnt_d = halt_cnt_q + 1'b1;
    end
  end

  // Accesses launched straight from IDLE use the live request fields.
  always_comb begin
    acc_cmd   = (state_q == StIdle) ? host_cmd   : cmd_q;
    acc_addr  = (state_q == StIdle) ? host_addr  : addr_q;
    acc_wdata = (state_q == StIdle) ? host_wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      halt_cnt_q  <= '0;
      core_halt_q <= 1'b0;
      core_halted <= 1'b0;
      host_ack    <= 1'b0;
      host_busy   <= 1'b0;
      host_rdata  <= '0;
      imem_we     <= 1'b0;
      dmem_we     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      reg_addr    <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      halt_cnt_q  <= halt_cnt_d;
      core_halt_q <= core_halt_d;
      core_halted <= (halt_cnt_d == DrainMax);
      imem_we     <= 1'b0;
      dmem_we     <= '0;

      unique case (state_q)
        StIdle, StHalt: begin
          if (state_q == StIdle && accept) begin
            cmd_q      <= host_cmd;
            addr_q     <= host_addr;
            wdata_q    <= host_wdata;
            host_busy  <= 1'b1;
            host_rdata <= '0;
            state_q    <= StHalt;
          end
          if ((state_q == StIdle && accept && halt_cnt_q == DrainMax) ||
              (state_q == StHalt && halt_cnt_d == DrainMax)) begin
            state_q   <= StAccess;
            mem_addr  <= acc_addr[31:2];
            reg_addr  <= acc_addr[4:0];
            mem_wdata <= acc_cmd[0] ? acc_wdata : 32'h0;
            imem_we   <= (acc_cmd == CmdImemWr);
            dmem_we   <= (acc_cmd == CmdDmemWr) ? 4'hf : 4'h0;
          end
        end
        StAccess: begin
          if (cmd_q[0]) begin
            state_q  <= StResp;
            host_ack <= 1'b1;
          end else begin
            state_q  <= StWait;
          end
        end
        StWait: begin
          host_rdata <= (cmd_q == CmdRegRd) ? reg_rdata : dmem_rdata;
          host_ack   <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (!host_req) begin
            state_q    <= StIdle;
            host_ack   <= 1'b0;
            host_busy  <= 1'b0;
            host_rdata <= '0;
            mem_addr   <= '0;
            reg_addr   <= '0;
            mem_wdata  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_halt = core_halt_q;

endmodule
